// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared widths, constants and FSM state encoding for the data-memory responder.
package data_mem_responder_pkg;
    localparam int REG_BUS = 32;
    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
    typedef enum logic [1:0] {
        DMR_IDLE,
        DMR_WAIT,
        DMR_DONE
    } dmr_state_e;
endpackage

// File: rtl/data_mem_responder_dmem_bank.sv
// dmem_bank: word-wide synchronous RAM with per-byte write enables and a registered read port.
module dmem_bank #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [2**AW];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: owns the data RAM, serves one load/store at a time with WAIT_CYCLES wait states.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_ce_i,
    input  logic               mem_we_i,
    input  logic [31:0]        mem_addr_i,
    input  logic [3:0]         mem_sel_i,
    input  logic [REG_BUS-1:0] mem_data_i,
    output logic [REG_BUS-1:0] mem_data_o,
    output logic               stallreq_o,
    output logic               ack_o,
    output logic               err_o
);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    dmr_state_e          r_state, w_next;
    logic [CW-1:0]       r_cnt;
    logic                r_we;
    logic [31:2]         r_addr;
    logic [3:0]          r_sel;
    logic [REG_BUS-1:0]  r_wdata, r_data;
    logic                w_idle, w_wait, w_oor, w_fire, w_unused_addr;
    logic [3:0]          w_bank_we;
    logic [DEPTH_LOG2-1:0] w_bank_addr;
    logic [REG_BUS-1:0]  w_bank_q;

    assign w_idle        = r_state == DMR_IDLE;
    assign w_wait        = r_state == DMR_WAIT;
    assign w_oor         = |r_addr[31:DEPTH_LOG2+2];
    assign w_fire        = w_wait && mem_ce_i && r_cnt == '0;
    assign w_bank_we     = {4{w_fire && r_we && !w_oor}} & r_sel;
    assign w_unused_addr = ^mem_addr_i[1:0];
    // Read the incoming address while idle so the RAM word is ready even with zero wait states.
    assign w_bank_addr   = w_idle ? mem_addr_i[DEPTH_LOG2+1:2] : r_addr[DEPTH_LOG2+1:2];

    assign stallreq_o = rst && ((w_idle && mem_ce_i) || w_wait);
    assign ack_o      = r_state == DMR_DONE;
    assign err_o      = ack_o && w_oor;
    assign mem_data_o = r_data;

    always_comb begin
        w_next = w_idle ? (mem_ce_i ? DMR_WAIT : DMR_IDLE)
               : w_wait ? (!mem_ce_i ? DMR_IDLE : (r_cnt == '0 ? DMR_DONE : DMR_WAIT))
               : DMR_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DMR_IDLE;
            r_cnt   <= '0;
            r_data  <= ZERO_WORD;
        end else begin
            r_state <= w_next;
            if (w_idle && mem_ce_i) r_cnt <= CW'(WAIT_CYCLES);
            else if (w_wait && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (w_fire && !r_we) r_data <= w_oor ? ZERO_WORD : w_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (w_idle) begin
            r_we    <= mem_we_i;
            r_addr  <= mem_addr_i[31:2];
            r_sel   <= mem_sel_i;
            r_wdata <= mem_data_i;
        end
    end

    dmem_bank #(.AW(DEPTH_LOG2)) u_bank (
        .clk     (clk),
        .i_we    (w_bank_we),
        .i_addr  (w_bank_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_bank_q)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and randomized checks of the responder against a word-array model.
module tb_data_mem_responder;
    localparam int WC = 2;

    logic        clk = 0, rst = 0;
    logic        ce = 0, we = 0, ce0 = 0, we0 = 0;
    logic [31:0] addr = 0, wdata = 0, addr0 = 0, wdata0 = 0;
    logic [3:0]  sel = 0, sel0 = 0;
    logic [31:0] rdata, rdata0;
    logic        stall, ack, err, stall0, ack0, err0;

    logic [31:0] ref_mem [1024];
    logic [31:0] last_d;
    int          n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .mem_ce_i(ce), .mem_we_i(we), .mem_addr_i(addr),
        .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rdata),
        .stallreq_o(stall), .ack_o(ack), .err_o(err)
    );

    data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_ce_i(ce0), .mem_we_i(we0), .mem_addr_i(addr0),
        .mem_sel_i(sel0), .mem_data_i(wdata0), .mem_data_o(rdata0),
        .stallreq_o(stall0), .ack_o(ack0), .err_o(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access on the WC-wait-state instance, checking every cycle from request to ack.
    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic        oor;
        logic [31:0] exp_d;
        int          wi;
        oor = |a[31:12];
        wi  = int'(a[11:2]);
        if (oor) exp_d = w ? last_d : 32'h0;
        else if (w) begin
            for (int i = 0; i < 4; i++) if (s[i]) ref_mem[wi][8*i +: 8] = d[8*i +: 8];
            exp_d = last_d;
        end else exp_d = ref_mem[wi];
        @(posedge clk); #1;
        ce = 1; we = w; addr = a; sel = s; wdata = d;
        for (int k = 0; k <= WC + 2; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (k <= WC + 1) begin
                    we = 1'($urandom); addr = $urandom; sel = 4'($urandom); wdata = $urandom;
                end else ce = 0;
            end
            @(negedge clk);
            if (k < WC + 2) begin
                chk("stall_pending", 32'(stall), 1);
                chk("ack_early", 32'(ack), 0);
            end else begin
                chk("ack_done", 32'(ack), 1);
                chk("stall_done", 32'(stall), 0);
                chk("err_done", 32'(err), 32'(oor));
                chk("rdata_done", rdata, exp_d);
            end
        end
        last_d = exp_d;
    endtask

    // Store that is abandoned by dropping ce at cycle T+drop_k; the model is left untouched.
    task automatic abort_store(input logic [31:0] a, input int drop_k);
        @(posedge clk); #1;
        ce = 1; we = 1; addr = a; sel = 4'hF; wdata = ~ref_mem[int'(a[11:2])];
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == drop_k) ce = 0;
            @(negedge clk);
            chk("abort_ack", 32'(ack), 0);
            if (k == drop_k + 1) chk("abort_idle_stall", 32'(stall), 0);
        end
    endtask

    initial begin
        last_d = 0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_data", rdata, 0);
        @(posedge clk); #1 rst = 1;

        for (int i = 0; i < 16; i++) access(1, 32'(i * 4), 4'hF, $urandom);
        access(1, 32'h10, 4'hF, 32'hDEADBEEF);
        access(0, 32'h10, 4'h3, 32'h0);
        chk("t1_load", rdata, 32'hDEADBEEF);
        access(1, 32'h11, 4'b0010, 32'h55555555);
        access(0, 32'h12, 4'h1, 32'h0);
        chk("t2_load", rdata, 32'hDEAD55EF);
        access(0, 32'h1000, 4'hF, 32'h0);
        access(1, 32'h1000, 4'hF, 32'hFFFFFFFF);
        access(0, 32'h0, 4'hF, 32'h0);
        access(1, 32'h8, 4'h0, 32'h12345678);
        access(0, 32'h8, 4'hF, 32'h0);

        abort_store(32'h20, 2);
        access(0, 32'h20, 4'hF, 32'h0);
        abort_store(32'h20, 3);
        access(0, 32'h20, 4'hF, 32'h0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 63));
            access(1'($urandom), a, 4'($urandom), $urandom);
        end

        // Asynchronous reset in the middle of a store's wait states.
        @(posedge clk); #1;
        ce = 1; we = 1; addr = 32'h14; sel = 4'hF; wdata = ~ref_mem[5];
        repeat (2) @(posedge clk);
        #3 rst = 0;
        #1;
        chk("arst_stall", 32'(stall), 0);
        chk("arst_ack", 32'(ack), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_data", rdata, 0);
        last_d = 0;
        repeat (2) @(posedge clk);
        #1 ce = 0;
        #2 rst = 1;
        access(0, 32'h14, 4'hF, 32'h0);

        // Zero-wait instance: seed two words, then two back-to-back loads with ce held.
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            ce0 = 1; we0 = 1; sel0 = 4'hF; addr0 = (j == 0) ? 32'hC : 32'h1C;
            wdata0 = (j == 0) ? 32'hA5A5_0003 : 32'h5A5A_0007;
            repeat (2) @(posedge clk);
            #1 ce0 = 0;
        end
        @(posedge clk); #1;
        ce0 = 1; we0 = 0; addr0 = 32'hC;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == 2) addr0 = 32'h1C;
            @(negedge clk);
            chk("w0_stall", 32'(stall0), (k == 2 || k == 5) ? 0 : 1);
            chk("w0_ack", 32'(ack0), (k == 2 || k == 5) ? 1 : 0);
            if (k == 2) chk("w0_load1", rdata0, 32'hA5A5_0003);
            if (k == 5) chk("w0_load2", rdata0, 32'h5A5A_0007);
        end
        @(posedge clk); #1 ce0 = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
